diskii_write_serializer: RTL and testbench
==========================================

DISKII_WRITE_SERIALIZER -- requirements
Module: diskii_write_serializer

Interface
REQ-001 SHALL have parameter BIT_CYCLES, default 4, meaning clk_logic cycles per bit cell (≥2).
REQ-002 SHALL have parameter TRACK_BYTES, default 6656, meaning nibble positions per track.
REQ-003 SHALL have port clk_logic  in  1  sole clock; all logic on rising edge.
REQ-004 SHALL have port system_reset  in  1  reset, synchronous, active-high.
REQ-005 SHALL have port drive_active_i  in  1  selected drive spinning.
REQ-006 SHALL have port write_mode_i  in  1  Q7 state; high = write mode.
REQ-007 SHALL have port load_i  in  1  one-cycle CPU write strobe to data latch.
REQ-008 SHALL have port data_i  in  8  byte written by CPU.
REQ-009 SHALL have port track_start_i  in  13  head byte offset, sampled at write start.
REQ-010 SHALL have port bit_o  out  1  serial write-data level of current bit cell.
REQ-011 SHALL have port bit_strobe_o  out  1  one-cycle pulse, last cycle of each bit cell.
REQ-012 SHALL have port nib_data_o  out  8  reassembled nibble.
REQ-013 SHALL have port nib_valid_o  out  1  nib_data_o/nib_addr_o valid.
REQ-014 SHALL have port nib_ready_i  in  1  track buffer accepts nibble.
REQ-015 SHALL have port nib_addr_o  out  13  track byte offset of nib_data_o.
REQ-016 SHALL have port overrun_o  out  1  sticky: completed nibble dropped.
REQ-017 SHALL have port busy_o  out  1  shifter in SHIFT state.

Function
REQ-018 SHALL define wr_en = write_mode_i & drive_active_i.
REQ-019 SHALL, on load_i with wr_en, write data_i to holding latch and set hold_full; load_i with wr_en low ignored; load_i while hold_full overwrites latch without flag.
REQ-020 SHALL implement states IDLE and SHIFT; IDLE->SHIFT when wr_en & hold_full: shifter<=latch, hold_full cleared, bit count 0, cell timer 0.
REQ-021 SHALL, in SHIFT, drive bit_o = shifter[7] for BIT_CYCLES cycles, pulse bit_strobe_o on last cycle, then shift left inserting 0; first strobe exactly BIT_CYCLES cycles after shifter load.
REQ-022 SHALL, after 8th bit strobe, reload shifter from latch in same cycle if hold_full (no gap), else continue emitting 0 bits, reloading at next cell boundary where hold_full is set (yields 10-bit sync nibbles).
REQ-023 SHALL, when load_i coincides with a reload, transfer old latch to shifter and store data_i in latch with hold_full set.
REQ-024 SHALL leave SHIFT for IDLE on cycle wr_en falls: bit_o=0, no strobes, hold_full and assembler cleared; a pending nib_valid_o is retained until accepted.
REQ-025 SHALL reassemble: on each bit_strobe_o, asm<=asm<<1|bit_o; leading 0s leave asm 0; when shifted asm[7]=1, load nib_data_o<=asm, nib_addr_o<=addr, set nib_valid_o, clear asm, all in the cycle after the strobe.
REQ-026 SHALL increment addr on every completed nibble (accepted or dropped), wrapping TRACK_BYTES-1 -> 0.
REQ-027 SHALL hold nib_valid_o and outputs stable until nib_valid_o & nib_ready_i, then clear valid next cycle.
REQ-028 SHALL, if a nibble completes while nib_valid_o is high and not handshaking that cycle, drop new nibble, keep old, set overrun_o; if handshake coincides, load new nibble and keep valid high.
REQ-029 SHALL, on wr_en rising, load addr<=track_start_i and clear overrun_o, asm.
REQ-030 SHALL drive busy_o high exactly while in SHIFT.

Reset
REQ-031 SHALL, on system_reset high at a clock edge, force IDLE, hold_full=0, shifter=0, asm=0, addr=0, bit_o=0, bit_strobe_o=0, nib_data_o=0, nib_valid_o=0, nib_addr_o=0, overrun_o=0, busy_o=0, regardless of state; reset dominates load_i.

Verification
REQ-032 SHALL verify: BIT_CYCLES=4, wr_en=1, track_start_i=100, load 0xD5 -> strobes every 4 cycles, bits 1,1,0,1,0,1,0,1; nib_data_o=0xD5, nib_addr_o=100 one cycle after 8th strobe.
REQ-033 SHALL verify: load 0xFF, then next load 2 cells after byte end -> bit_o shows 8 ones, 2 zeros; both nibbles 0xFF at addr 100,101.
REQ-034 SHALL verify: back-to-back loads 0xD5,0xAA,0x96 each before prior byte ends -> 24 contiguous cells, nibbles at consecutive addresses, busy_o high throughout.
REQ-035 SHALL verify: track_start_i=6655, two nibbles -> nib_addr_o 6655 then 0.
REQ-036 SHALL verify: nib_ready_i=0 across two completions -> first nibble held, overrun_o=1, second consumes addr+1; wr_en toggle clears overrun_o.
REQ-037 SHALL verify: wr_en dropped mid-byte, and system_reset asserted mid-byte -> bit strobes stop next cycle, no partial nibble emitted, reset values per REQ-031.

Source files
------------

// File: rtl/diskii_write_serializer.sv
// rtl/diskii_write_serializer.sv - Disk II write-data serializer with nibble reassembly
module diskii_write_serializer #(
  parameter int BIT_CYCLES  = 4,
  parameter int TRACK_BYTES = 6656
) (
  input  logic        clk_logic,
  input  logic        system_reset,
  input  logic        drive_active_i,
  input  logic        write_mode_i,
  input  logic        load_i,
  input  logic [7:0]  data_i,
  input  logic [12:0] track_start_i,
  output logic        bit_o,
  output logic        bit_strobe_o,
  output logic [7:0]  nib_data_o,
  output logic        nib_valid_o,
  input  logic        nib_ready_i,
  output logic [12:0] nib_addr_o,
  output logic        overrun_o,
  output logic        busy_o
);

  localparam int TW = $clog2(BIT_CYCLES);
  localparam logic [TW-1:0] LAST_CYCLE = TW'(BIT_CYCLES - 1);
  localparam logic [12:0]   ADDR_LAST  = 13'(TRACK_BYTES - 1);

  typedef enum logic {IDLE, SHIFT} state_t;

  state_t        state, state_nxt;
  logic          hold_full;
  logic [7:0]    latch;
  logic [7:0]    shifter, shifter_nxt;
  logic [TW-1:0] timer, timer_nxt;
  logic [2:0]    bit_cnt;
  logic          tail;
  logic          wr_en, wr_en_q, wr_rise;
  logic          cell_end, byte_end, reload;
  logic [7:0]    asm_reg, asm_shift;
  logic [12:0]   addr;
  logic          nib_done;

  // Cell/byte boundary decode and next values shared by the shifter registers
  always_comb begin
    wr_en       = write_mode_i & drive_active_i;
    wr_rise     = wr_en & ~wr_en_q;
    cell_end    = (state == SHIFT) && (timer == LAST_CYCLE);
    // tail: past the 8th bit and padding with zero cells until a byte is held
    byte_end    = cell_end && ((bit_cnt == 3'd7) || tail);
    reload      = wr_en && hold_full && ((state == IDLE) || byte_end);
    state_nxt   = !wr_en ? IDLE : (reload ? SHIFT : state);
    shifter_nxt = shifter;
    if (reload)
      shifter_nxt = latch;
    else if (cell_end)
      shifter_nxt = {shifter[6:0], 1'b0};
    timer_nxt = timer + 1'b1;
    if (state_nxt != SHIFT || reload || cell_end)
      timer_nxt = '0;
    asm_shift = {asm_reg[6:0], bit_o};
    nib_done  = wr_en && bit_strobe_o && asm_shift[7];
  end

  // Holding latch, shifter FSM and serial outputs
  always_ff @(posedge clk_logic) begin
    if (system_reset) begin
      state        <= IDLE;
      hold_full    <= 1'b0;
      latch        <= 8'h00;
      shifter      <= 8'h00;
      timer        <= '0;
      bit_cnt      <= 3'd0;
      tail         <= 1'b0;
      bit_o        <= 1'b0;
      bit_strobe_o <= 1'b0;
      busy_o       <= 1'b0;
    end else begin
      state        <= state_nxt;
      shifter      <= shifter_nxt;
      timer        <= timer_nxt;
      bit_o        <= (state_nxt == SHIFT) && shifter_nxt[7];
      bit_strobe_o <= (state_nxt == SHIFT) && (timer_nxt == LAST_CYCLE);
      busy_o       <= (state_nxt == SHIFT);
      if (reload)
        bit_cnt <= 3'd0;
      else if (cell_end)
        bit_cnt <= bit_cnt + 3'd1;
      if (state_nxt != SHIFT || reload)
        tail <= 1'b0;
      else if (byte_end)
        tail <= 1'b1;
      // A load coinciding with a reload keeps the new byte: the shifter takes the old latch
      if (!wr_en) begin
        hold_full <= 1'b0;
      end else if (load_i) begin
        latch     <= data_i;
        hold_full <= 1'b1;
      end else if (reload) begin
        hold_full <= 1'b0;
      end
    end
  end

  // Nibble reassembly, track address and output handshake
  always_ff @(posedge clk_logic) begin
    if (system_reset) begin
      wr_en_q     <= 1'b0;
      asm_reg     <= 8'h00;
      addr        <= 13'd0;
      nib_data_o  <= 8'h00;
      nib_addr_o  <= 13'd0;
      nib_valid_o <= 1'b0;
      overrun_o   <= 1'b0;
    end else begin
      wr_en_q <= wr_en;
      if (!wr_en || wr_rise || nib_done)
        asm_reg <= 8'h00;
      else if (bit_strobe_o)
        asm_reg <= asm_shift;
      if (wr_rise)
        addr <= track_start_i;
      else if (nib_done)
        addr <= (addr == ADDR_LAST) ? 13'd0 : addr + 13'd1;
      if (wr_rise)
        overrun_o <= 1'b0;
      else if (nib_done && nib_valid_o && !nib_ready_i)
        overrun_o <= 1'b1;
      if (nib_done && (!nib_valid_o || nib_ready_i)) begin
        nib_data_o  <= asm_shift;
        nib_addr_o  <= addr;
        nib_valid_o <= 1'b1;
      end else if (nib_valid_o && nib_ready_i) begin
        nib_valid_o <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_diskii_write_serializer.sv
// tb/tb_diskii_write_serializer.sv - directed self-checking bench for diskii_write_serializer
module tb_diskii_write_serializer;

  logic        clk_logic = 1'b0;
  logic        system_reset = 1'b1;
  logic        drive_active_i = 1'b1;
  logic        write_mode_i = 1'b0;
  logic        load_i = 1'b0;
  logic [7:0]  data_i = 8'h00;
  logic [12:0] track_start_i = 13'd0;
  logic        nib_ready_i = 1'b1;
  logic        bit_o, bit_strobe_o, nib_valid_o, overrun_o, busy_o;
  logic [7:0]  nib_data_o;
  logic [12:0] nib_addr_o;

  int total = 0;
  int bad = 0;
  logic [20:0] nq[$];

  diskii_write_serializer #(.BIT_CYCLES(4), .TRACK_BYTES(6656)) dut (
    .clk_logic(clk_logic), .system_reset(system_reset), .drive_active_i(drive_active_i),
    .write_mode_i(write_mode_i), .load_i(load_i), .data_i(data_i),
    .track_start_i(track_start_i), .bit_o(bit_o), .bit_strobe_o(bit_strobe_o),
    .nib_data_o(nib_data_o), .nib_valid_o(nib_valid_o), .nib_ready_i(nib_ready_i),
    .nib_addr_o(nib_addr_o), .overrun_o(overrun_o), .busy_o(busy_o)
  );

  always #5 clk_logic = ~clk_logic;

  // Record every accepted nibble as {addr, data}
  always @(negedge clk_logic) begin
    #1;
    if (nib_valid_o && nib_ready_i) nq.push_back({nib_addr_o, nib_data_o});
  end

  initial begin
    #100000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic load_byte(input logic [7:0] v);
    load_i = 1'b1;
    data_i = v;
    @(negedge clk_logic);
    load_i = 1'b0;
  endtask

  task automatic wait_strobe(output logic b, output int n);
    n = 0;
    do begin
      @(negedge clk_logic);
      n++;
    end while (!bit_strobe_o && n < 40);
    b = bit_o;
  endtask

  task automatic run_byte(input string tag, input logic [7:0] v, input int first_gap);
    logic b;
    int n;
    for (int i = 0; i < 8; i++) begin
      wait_strobe(b, n);
      chk({tag, "_gap"}, n, (i == 0) ? first_gap : 4);
      chk({tag, "_bit"}, b, v[7-i]);
      chk({tag, "_busy"}, busy_o, 1);
    end
  endtask

  task automatic start_write(input logic [12:0] ts);
    write_mode_i = 1'b0;
    @(negedge clk_logic);
    track_start_i = ts;
    write_mode_i = 1'b1;
    @(negedge clk_logic);
  endtask

  task automatic wait_q(input string tag, input int want);
    int n;
    n = 0;
    while (nq.size() < want && n < 100) begin
      @(negedge clk_logic);
      n++;
    end
    chk({tag, "_qsize"}, nq.size(), want);
  endtask

  initial begin
    logic b;
    int n, s;

    // reset state
    repeat (3) @(negedge clk_logic);
    chk("rst_bit", bit_o, 0);
    chk("rst_strobe", bit_strobe_o, 0);
    chk("rst_valid", nib_valid_o, 0);
    chk("rst_data", nib_data_o, 0);
    chk("rst_addr", nib_addr_o, 0);
    chk("rst_overrun", overrun_o, 0);
    chk("rst_busy", busy_o, 0);
    system_reset = 1'b0;

    // single byte 0xD5 at address 100
    start_write(13'd100);
    nq.delete();
    load_byte(8'hD5);
    run_byte("t1", 8'hD5, 4);
    @(negedge clk_logic);
    chk("t1_valid", nib_valid_o, 1);
    chk("t1_data", nib_data_o, 8'hD5);
    chk("t1_addr", nib_addr_o, 100);

    // 0xFF then two sync zero cells then 0xFF
    start_write(13'd100);
    nq.delete();
    load_byte(8'hFF);
    run_byte("t2a", 8'hFF, 4);
    wait_strobe(b, n);
    chk("t2_z1_gap", n, 4);
    chk("t2_z1_bit", b, 0);
    load_byte(8'hFF);
    wait_strobe(b, n);
    chk("t2_z2_gap", n, 3);
    chk("t2_z2_bit", b, 0);
    run_byte("t2b", 8'hFF, 4);
    wait_q("t2", 2);
    chk("t2_n0", nq[0], {13'd100, 8'hFF});
    chk("t2_n1", nq[1], {13'd101, 8'hFF});

    // back-to-back D5 AA 96, second load hits the idle->shift reload, third hits a byte-end reload
    start_write(13'd200);
    nq.delete();
    load_byte(8'hD5);
    load_byte(8'hAA);
    run_byte("t3a", 8'hD5, 3);
    load_byte(8'h96);
    run_byte("t3b", 8'hAA, 3);
    run_byte("t3c", 8'h96, 4);
    wait_q("t3", 3);
    chk("t3_n0", nq[0], {13'd200, 8'hD5});
    chk("t3_n1", nq[1], {13'd201, 8'hAA});
    chk("t3_n2", nq[2], {13'd202, 8'h96});

    // address wrap at end of track
    start_write(13'd6655);
    nq.delete();
    load_byte(8'hD5);
    run_byte("t4a", 8'hD5, 4);
    load_byte(8'h96);
    wait_strobe(b, n);
    chk("t4_z_gap", n, 3);
    chk("t4_z_bit", b, 0);
    run_byte("t4b", 8'h96, 4);
    wait_q("t4", 2);
    chk("t4_n0", nq[0], {13'd6655, 8'hD5});
    chk("t4_n1", nq[1], {13'd0, 8'h96});

    // overrun with ready low across two completions
    start_write(13'd300);
    nq.delete();
    nib_ready_i = 1'b0;
    load_byte(8'hD5);
    repeat (2) @(negedge clk_logic);
    load_byte(8'hAA);
    run_byte("t5a", 8'hD5, 1);
    run_byte("t5b", 8'hAA, 4);
    @(negedge clk_logic);
    chk("t5_valid", nib_valid_o, 1);
    chk("t5_data", nib_data_o, 8'hD5);
    chk("t5_addr", nib_addr_o, 300);
    chk("t5_overrun", overrun_o, 1);
    nib_ready_i = 1'b1;
    load_byte(8'h96);
    wait_q("t5", 2);
    chk("t5_n0", nq[0], {13'd300, 8'hD5});
    chk("t5_n1", nq[1], {13'd302, 8'h96});
    chk("t5_sticky", overrun_o, 1);
    start_write(13'd300);
    chk("t5_ovr_clear", overrun_o, 0);

    // write enable dropped mid-byte
    start_write(13'd400);
    nq.delete();
    load_byte(8'hD5);
    repeat (3) wait_strobe(b, n);
    write_mode_i = 1'b0;
    @(negedge clk_logic);
    chk("t6_strobe", bit_strobe_o, 0);
    chk("t6_busy", busy_o, 0);
    chk("t6_bit", bit_o, 0);
    s = 0;
    repeat (20) begin
      @(negedge clk_logic);
      if (bit_strobe_o) s++;
    end
    chk("t6_no_strobe", s, 0);
    chk("t6_no_nib", nq.size(), 0);
    start_write(13'd400);
    s = 0;
    repeat (12) begin
      @(negedge clk_logic);
      if (busy_o) s++;
    end
    chk("t6_hold_cleared", s, 0);

    // reset mid-byte, with a coinciding load that must be ignored
    start_write(13'd500);
    nq.delete();
    load_byte(8'hAA);
    repeat (3) wait_strobe(b, n);
    system_reset = 1'b1;
    load_i = 1'b1;
    data_i = 8'h96;
    @(negedge clk_logic);
    chk("t7_bit", bit_o, 0);
    chk("t7_strobe", bit_strobe_o, 0);
    chk("t7_busy", busy_o, 0);
    chk("t7_valid", nib_valid_o, 0);
    chk("t7_data", nib_data_o, 0);
    chk("t7_addr", nib_addr_o, 0);
    chk("t7_overrun", overrun_o, 0);
    system_reset = 1'b0;
    load_i = 1'b0;
    s = 0;
    repeat (12) begin
      @(negedge clk_logic);
      if (busy_o || bit_strobe_o) s++;
    end
    chk("t7_quiet", s, 0);
    chk("t7_no_nib", nq.size(), 0);
    load_byte(8'hD5);
    run_byte("t7", 8'hD5, 4);
    @(negedge clk_logic);
    chk("t7_nvalid", nib_valid_o, 1);
    chk("t7_ndata", nib_data_o, 8'hD5);
    chk("t7_naddr", nib_addr_o, 500);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
